// File: rtl/inv_mix_cols_seq.sv
// Sequential AES InvMixColumns: accepts a 128-bit state, mixes COLS_PER_CYCLE columns per clock,
// and holds the result on a valid/ready output until it is taken.
module inv_mix_cols_seq #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   localparam logic [2:0] Step  = 3'(COLS_PER_CYCLE);
   localparam logic [2:0] LastK = 3'(4 - COLS_PER_CYCLE);

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [0:3][31:0] work_q, work_d;
   logic             out_valid_q, out_valid_d;
   logic [127:0]     out_state_q, out_state_d;
   logic [1:0]       col_idx;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] s  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int unsigned i = 0; i < 4; i++) begin
         s[i]  = c[31-8*i -: 8];
         x2    = xtime(s[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ s[i];
         mb[i] = x8 ^ x2 ^ s[i];
         md[i] = x8 ^ x4 ^ s[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // In DONE a new state may be taken on the same edge the result is consumed.
   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         StIdle:  in_ready = 1'b1;
         StDone:  in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      out_valid_d = out_valid_q;
      out_state_d = out_state_q;
      col_idx     = '0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               work_d  = in_state;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
               col_idx         = cnt_q[1:0] + 2'(j);
               work_d[col_idx] = inv_mix_col(work_q[col_idx]);
            end
            cnt_d = cnt_q + Step;
            if (cnt_q == LastK) begin
               state_d     = StDone;
               out_valid_d = 1'b1;
               out_state_d = work_d;
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
               if (in_valid) begin
                  work_d  = in_state;
                  cnt_d   = '0;
                  state_d = StBusy;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         work_q      <= '0;
         out_valid_q <= 1'b0;
         out_state_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         out_valid_q <= out_valid_d;
         out_state_q <= out_state_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_state = out_state_q;

endmodule

// File: tb/tb_inv_mix_cols_seq.sv
// Bench for inv_mix_cols_seq: one instance each for COLS_PER_CYCLE = 1, 2, 4, driven by directed
// vectors, handshake corner cases and a forward-MixColumns round trip.
module tb_inv_mix_cols_seq;

   logic         clk;
   logic         rst       [3];
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_state  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_state [3];

   int errors;
   int checks;

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
      string        name;
   } vec_t;

   vec_t vecs [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inv_mix_cols_seq #(
         .COLS_PER_CYCLE(1 << g)
      ) u_dut (
         .clk      (clk),
         .rst      (rst[g]),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .in_state (in_state[g]),
         .out_valid(out_valid[g]),
         .out_ready(out_ready[g]),
         .out_state(out_state[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Forward MixColumns, used only to build round-trip stimulus.
   function automatic logic [127:0] fwd_mix(input logic [127:0] st);
      logic [127:0] r;
      logic [7:0]   s0, s1, s2, s3;
      for (int c = 0; c < 4; c++) begin
         s0 = st[127-32*c -: 8];
         s1 = st[119-32*c -: 8];
         s2 = st[111-32*c -: 8];
         s3 = st[103-32*c -: 8];
         r[127-32*c -: 32] = {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
                              s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
                              s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
                              xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input int i, output int lat);
      lat = 0;
      while (!out_valid[i] && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic run_one(input int i, input logic [127:0] din, input logic [127:0] exp,
                          input string name);
      int lat;
      int lim;
      lim = 0;
      while (!in_ready[i] && lim < 20) begin
         step();
         lim++;
      end
      in_valid[i]  = 1'b1;
      in_state[i]  = din;
      out_ready[i] = 1'b0;
      step();
      in_valid[i] = 1'b0;
      in_state[i] = 'x;
      wait_out(i, lat);
      chk($sformatf("d%0d %s latency", i, name), 128'(lat), 128'(4 >> i));
      chk($sformatf("d%0d %s data", i, name), out_state[i], exp);
      out_ready[i] = 1'b1;
      step();
      out_ready[i] = 1'b0;
      chk($sformatf("d%0d %s out_valid drop", i, name), 128'(out_valid[i]), 128'(0));
      chk($sformatf("d%0d %s in_ready after", i, name), 128'(in_ready[i]), 128'(1));
   endtask

   initial begin
      int lat;
      logic [127:0] orig;
      errors = 0;
      checks = 0;
      vecs[0] = '{128'h046681e5e0cb199a48f8d37a2806264c,
                  128'hd4bf5d30e0b452aeb84111f11e2798e5, "fips_b"};
      vecs[1] = '{128'h8e4da1bc9fdc589d01010101c6c6c6c6,
                  128'hdb135345f20a225c01010101c6c6c6c6, "columns"};
      vecs[2] = '{128'hffffffffffffffffffffffffffffffff,
                  128'hffffffffffffffffffffffffffffffff, "all_ff"};

      for (int i = 0; i < 3; i++) begin
         rst[i]       = 1'b1;
         in_valid[i]  = 1'b0;
         in_state[i]  = '0;
         out_ready[i] = 1'b0;
      end
      repeat (3) step();
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d%0d reset out_valid", i), 128'(out_valid[i]), 128'(0));
         chk($sformatf("d%0d reset out_state", i), out_state[i], 128'h0);
         chk($sformatf("d%0d reset in_ready", i), 128'(in_ready[i]), 128'(1));
      end

      for (int i = 0; i < 3; i++)
         for (int v = 0; v < 3; v++)
            run_one(i, vecs[v].din, vecs[v].dout, vecs[v].name);

      // Backpressure: result must stay put for 10 stalled cycles.
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b1;
         in_state[i] = vecs[1].din;
         step();
         in_valid[i] = 1'b0;
         wait_out(i, lat);
         chk($sformatf("d%0d bp latency", i), 128'(lat), 128'(4 >> i));
         for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("d%0d bp data c%0d", i, c), out_state[i], vecs[1].dout);
            chk($sformatf("d%0d bp valid c%0d", i, c), 128'(out_valid[i]), 128'(1));
            chk($sformatf("d%0d bp in_ready c%0d", i, c), 128'(in_ready[i]), 128'(0));
         end
         out_ready[i] = 1'b1;
         #1;
         chk($sformatf("d%0d bp comb in_ready", i), 128'(in_ready[i]), 128'(1));
         step();
         out_ready[i] = 1'b0;
         chk($sformatf("d%0d bp release valid", i), 128'(out_valid[i]), 128'(0));
         chk($sformatf("d%0d bp release in_ready", i), 128'(in_ready[i]), 128'(1));
      end

      // Back-to-back: second state taken on the edge the first completes.
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b1;
         in_state[i]  = vecs[0].din;
         out_ready[i] = 1'b1;
         step();
         in_state[i] = vecs[1].din;
         wait_out(i, lat);
         chk($sformatf("d%0d b2b first latency", i), 128'(lat), 128'(4 >> i));
         chk($sformatf("d%0d b2b first data", i), out_state[i], vecs[0].dout);
         chk($sformatf("d%0d b2b overlap ready", i), 128'(in_ready[i]), 128'(1));
         step();
         in_valid[i] = 1'b0;
         in_state[i] = 'x;
         chk($sformatf("d%0d b2b valid drop", i), 128'(out_valid[i]), 128'(0));
         wait_out(i, lat);
         chk($sformatf("d%0d b2b second latency", i), 128'(lat), 128'(4 >> i));
         chk($sformatf("d%0d b2b second data", i), out_state[i], vecs[1].dout);
         step();
         out_ready[i] = 1'b0;
         chk($sformatf("d%0d b2b end ready", i), 128'(in_ready[i]), 128'(1));
      end

      // Reset on the second cycle after acceptance discards the work.
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b1;
         in_state[i] = vecs[0].din;
         step();
         in_valid[i] = 1'b0;
         step();
         rst[i] = 1'b1;
         step();
         rst[i] = 1'b0;
         chk($sformatf("d%0d midrst out_valid", i), 128'(out_valid[i]), 128'(0));
         chk($sformatf("d%0d midrst out_state", i), out_state[i], 128'h0);
         chk($sformatf("d%0d midrst in_ready", i), 128'(in_ready[i]), 128'(1));
         run_one(i, vecs[1].din, vecs[1].dout, "after_rst");
      end

      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 1000; n++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            run_one(i, fwd_mix(orig), orig, "roundtrip");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
